// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// Plain 2:1 bus mux: y = s ? b : a.
module mux2_bus #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 valid/ready datapath,
// with a per-grant beat limit so neither burst requester can starve the other.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             ready0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             ready1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam int unsigned BW = WIDTH + 1;

  arb_state_t    state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          sel_d;
  logic          owner;
  logic          cur_req, cur_last, other_req;
  logic          beat;
  logic [BW-1:0] mux_y;

  assign owner     = (state_q == BUSY1);
  assign cur_req   = owner ? req1  : req0;
  assign cur_last  = owner ? last1 : last0;
  assign other_req = owner ? req0  : req1;
  assign cnt_inc   = cnt_q + CW'(1);

  // State, priority and beat-count registers; grant/select follow next state.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      sel     <= SEL_A;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      gnt0    <= (state_d == BUSY0);
      gnt1    <= (state_d == BUSY1);
    end
  end

  // Next-state: a grant ends on a last beat or on the beat reaching MAX_HOLD.
  // A requester cut short by the limit (no last yet) is re-granted if alone.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = prio_q ? BUSY1 : BUSY0;
        else if (req0)     state_d = BUSY0;
        else if (req1)     state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        beat = cur_req && out_ready;
        if (beat) begin
          if (cur_last || (cnt_inc == CW'(MAX_HOLD))) begin
            prio_d = ~owner;
            cnt_d  = '0;
            if (other_req)      state_d = owner ? BUSY0 : BUSY1;
            else if (!cur_last) state_d = state_q;
            else                state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      BUSY0:   sel_d = SEL_A;
      BUSY1:   sel_d = SEL_B;
      default: sel_d = sel;
    endcase
  end

  // Handshake outputs are blocked for the whole reset cycle.
  assign out_valid = n_reset && ((gnt0 && req0) || (gnt1 && req1));
  assign ready0    = n_reset && gnt0 && out_ready;
  assign ready1    = n_reset && gnt1 && out_ready;

  mux2_bus #(.WIDTH(BW)) u_mux (
    .a ({last0, data0}),
    .b ({last1, data1}),
    .s (sel),
    .y (mux_y)
  );

  assign {out_last, out_data} = mux_y;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: queued burst sources, in-order beat checking.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       req0, last0, ready0;
  logic [7:0] data0;
  logic       req1, last1, ready1;
  logic [7:0] data1;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, gnt0, gnt1;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req0      (req0),
    .data0     (data0),
    .last0     (last0),
    .ready0    (ready0),
    .req1      (req1),
    .data1     (data1),
    .last1     (last1),
    .ready1    (ready1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    req0 = (src0.size() != 0);
    {last0, data0} = req0 ? src0[0] : 9'h000;
    req1 = (src1.size() != 0);
    {last1, data1} = req1 ? src1[0] : 9'h000;
  endtask

  task automatic add_beat(input int who, input logic [7:0] d, input logic l);
    if (who == 0) src0.push_back({l, d});
    else          src1.push_back({l, d});
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // One cycle: sample at negedge, retire accepted source beats after posedge.
  task automatic tick();
    logic       f0, f1;
    logic [8:0] e;
    logic [8:0] tmp;
    @(negedge clk);
    f0 = req0 && ready0;
    f1 = req1 && ready1;
    check("onehot", 32'(gnt0 & gnt1), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'({out_last, out_data}), 32'h1ff);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({out_last, out_data}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (f0) tmp = src0.pop_front();
    if (f1) tmp = src1.pop_front();
    drive_srcs();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset   = 1'b0;
    out_ready = 1'b1;
    req0 = 1'b1; data0 = 8'h00; last0 = 1'b0;
    req1 = 1'b1; data1 = 8'h00; last1 = 1'b0;

    // Reset held with both requesting
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_ready0", 32'(ready0), 32'd0);
      check("rst_ready1", 32'(ready1), 32'd0);
    end
    n_reset = 1'b1;
    drive_srcs();

    // Single burst on req0
    add_beat(0, 8'hA1, 1'b0); add_beat(0, 8'hA2, 1'b0); add_beat(0, 8'hA3, 1'b1);
    expect_beat(8'hA1, 1'b0); expect_beat(8'hA2, 1'b0); expect_beat(8'hA3, 1'b1);
    drive_srcs();
    check("t2_gnt0_idle", 32'(gnt0), 32'd0);
    tick();
    check("t2_gnt0_granted", 32'(gnt0), 32'd1);
    repeat (3) tick();
    check("t2_all_beats", 32'(exp_q.size()), 32'd0);
    check("t2_idle_gnt0", 32'(gnt0), 32'd0);
    check("t2_idle_gnt1", 32'(gnt1), 32'd0);

    // Tie after reset: req0 first, no bubble into req1
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    add_beat(0, 8'hB1, 1'b0); add_beat(0, 8'hB2, 1'b1);
    add_beat(1, 8'hC1, 1'b0); add_beat(1, 8'hC2, 1'b1);
    expect_beat(8'hB1, 1'b0); expect_beat(8'hB2, 1'b1);
    expect_beat(8'hC1, 1'b0); expect_beat(8'hC2, 1'b1);
    drive_srcs();
    tick();
    check("t3_tie_gnt0", 32'(gnt0), 32'd1);
    repeat (2) tick();
    check("t3_switch_gnt1", 32'(gnt1), 32'd1);
    check("t3_switch_sel", 32'(sel), 32'd1);
    repeat (2) tick();
    check("t3_idle_gnt1", 32'(gnt1), 32'd0);
    check("t3_sel_hold", 32'(sel), 32'd1);
    add_beat(0, 8'hD0, 1'b1); add_beat(1, 8'hD1, 1'b1);
    expect_beat(8'hD0, 1'b1); expect_beat(8'hD1, 1'b1);
    drive_srcs();
    tick();
    check("t3_tie2_gnt0", 32'(gnt0), 32'd1);
    drain("t3_drain", 8);

    // Starvation bound: 10-beat burst cut at 4 beats
    for (int i = 0; i < 10; i++) add_beat(0, 8'(8'hE0 + i), (i == 9));
    add_beat(1, 8'hF0, 1'b0); add_beat(1, 8'hF1, 1'b1);
    for (int i = 0; i < 4; i++) expect_beat(8'(8'hE0 + i), 1'b0);
    expect_beat(8'hF0, 1'b0); expect_beat(8'hF1, 1'b1);
    for (int i = 4; i < 10; i++) expect_beat(8'(8'hE0 + i), (i == 9));
    drive_srcs();
    tick();
    check("t4_gnt0", 32'(gnt0), 32'd1);
    repeat (4) tick();
    check("t4_cut_gnt1", 32'(gnt1), 32'd1);
    repeat (2) tick();
    check("t4_back_gnt0", 32'(gnt0), 32'd1);
    drain("t4_drain", 20);
    check("t4_src0_empty", 32'(src0.size()), 32'd0);
    check("t4_idle_gnt0", 32'(gnt0), 32'd0);

    // Backpressure on beat 2 of 3
    add_beat(0, 8'h51, 1'b0); add_beat(0, 8'h52, 1'b0); add_beat(0, 8'h53, 1'b1);
    expect_beat(8'h51, 1'b0); expect_beat(8'h52, 1'b0); expect_beat(8'h53, 1'b1);
    drive_srcs();
    repeat (2) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall_data", 32'(out_data), 32'h52);
      check("t5_stall_valid", 32'(out_valid), 32'd1);
      check("t5_stall_gnt0", 32'(gnt0), 32'd1);
      check("t5_stall_ready0", 32'(ready0), 32'd0);
    end
    out_ready = 1'b1;
    drain("t5_drain", 6);
    check("t5_idle_gnt0", 32'(gnt0), 32'd0);

    // Reset during req1 burst, beat 2
    add_beat(1, 8'h61, 1'b0); add_beat(1, 8'h62, 1'b0); add_beat(1, 8'h63, 1'b1);
    expect_beat(8'h61, 1'b0);
    drive_srcs();
    tick();
    check("t6_gnt1", 32'(gnt1), 32'd1);
    check("t6_sel", 32'(sel), 32'd1);
    tick();
    n_reset = 1'b0;
    #1;
    check("t6_rst_ready1", 32'(ready1), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    tick();
    n_reset = 1'b1;
    check("t6_post_gnt1", 32'(gnt1), 32'd0);
    check("t6_post_gnt0", 32'(gnt0), 32'd0);
    check("t6_post_sel", 32'(sel), 32'd0);
    check("t6_no_extra_beat", 32'(exp_q.size()), 32'd0);
    src1.delete();
    add_beat(0, 8'h70, 1'b1); add_beat(1, 8'h71, 1'b1);
    expect_beat(8'h70, 1'b1); expect_beat(8'h71, 1'b1);
    drive_srcs();
    tick();
    check("t6_tie_gnt0", 32'(gnt0), 32'd1);
    drain("t6_drain", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
